// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, FSM states and flag bundle shared by the ula_seq slice
package ula_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;
  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;
  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic neg;
    logic err;
  } flags_t;
endpackage

// File: rtl/ula_seq_if.sv
// ula_seq_if: request/response bundle between the input layer and the ULA
interface ula_seq_if #(parameter int WIDTH = 4);
  logic start;
  logic [2:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
  logic acc_sel;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] result;
  logic flag_zero;
  logic flag_carry;
  logic flag_ovf;
  logic flag_neg;
  logic flag_err;
  modport master (
    output start, op, a, b, cin, acc_sel,
    input busy, done, result, flag_zero, flag_carry, flag_ovf, flag_neg, flag_err
  );
  modport slave (
    input start, op, a, b, cin, acc_sel,
    output busy, done, result, flag_zero, flag_carry, flag_ovf, flag_neg, flag_err
  );
endinterface

// File: rtl/ula_seq_muldiv.sv
// ula_seq_muldiv: shift-add multiplier / restoring divider on one shared 2*WIDTH register
module ula_seq_muldiv #(parameter int WIDTH = 4) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic mode,
  input  logic step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic done,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] r;
  logic [WIDTH-1:0] m;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rs;
  logic [WIDTH-1:0] diff;
  logic ge;
  // result is the register value after the current step, so it is final when done is high
  always_comb begin
    sum = {1'b0, r[2*WIDTH-1:WIDTH]} + (r[0] ? {1'b0, m} : '0);
    rs = {r[2*WIDTH-1:WIDTH], r[WIDTH-1]};
    ge = rs >= {1'b0, m};
    diff = rs[WIDTH-1:0] - m;
    result = mode ? {ge ? diff : rs[WIDTH-1:0], r[WIDTH-2:0], ge} : {sum, r[WIDTH-1:1]};
  end
  assign done = step && cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      m <= '0;
      cnt <= '0;
    end else if (load) begin
      r <= {{WIDTH{1'b0}}, a};
      m <= b;
      cnt <= CW'(WIDTH);
    end else if (step) begin
      r <= result;
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequential ULA with 1-cycle add/sub/logic and WIDTH-cycle mul/div; ULA_ACC_EN adds an accumulator
module ula_seq import ula_pkg::*; #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  ula_seq_if.slave bus
);
  state_t state, state_nxt;
  flags_t flg, flg_sc, flg_nxt;
  logic [2*WIDTH-1:0] res, res_sc, res_nxt, md_res;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH:0] add_r, sub_r;
  logic div_q, md_load, md_step, md_done, res_ld;
`ifdef ULA_ACC_EN
  logic [WIDTH-1:0] acc;
  assign a_eff = bus.acc_sel ? acc : bus.a;
  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (state == FIN) acc <= res[WIDTH-1:0];
  end
`else
  logic unused_acc_sel;
  assign unused_acc_sel = bus.acc_sel;
  assign a_eff = bus.a;
`endif
  always_comb begin
    add_r = {1'b0, a_eff} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    sub_r = {1'b0, a_eff} - {1'b0, bus.b};
    res_sc = '0;
    flg_sc = '0;
    case (bus.op)
      OP_ADD: begin
        res_sc = {{(WIDTH-1){1'b0}}, add_r};
        flg_sc.carry = add_r[WIDTH];
        flg_sc.ovf = (a_eff[WIDTH-1] == bus.b[WIDTH-1]) && (add_r[WIDTH-1] != a_eff[WIDTH-1]);
      end
      OP_SUB: begin
        res_sc = {{WIDTH{1'b0}}, sub_r[WIDTH-1:0]};
        flg_sc.carry = ~sub_r[WIDTH];
        flg_sc.ovf = (a_eff[WIDTH-1] != bus.b[WIDTH-1]) && (sub_r[WIDTH-1] != a_eff[WIDTH-1]);
        flg_sc.neg = sub_r[WIDTH];
      end
      OP_AND: res_sc = {{WIDTH{1'b0}}, a_eff & bus.b};
      OP_OR:  res_sc = {{WIDTH{1'b0}}, a_eff | bus.b};
      OP_XOR: res_sc = {{WIDTH{1'b0}}, a_eff ^ bus.b};
      // only reached with b == 0; nonzero divisors take the iterative path
      OP_DIV: begin
        res_sc = {a_eff, {WIDTH{1'b1}}};
        flg_sc.err = 1'b1;
      end
      OP_RSV: flg_sc.err = 1'b1;
      default: ;
    endcase
  end
  always_comb begin
    state_nxt = state;
    md_load = 1'b0;
    md_step = 1'b0;
    res_ld = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        if (bus.op == OP_MUL || (bus.op == OP_DIV && bus.b != '0)) begin
          state_nxt = ITER;
          md_load = 1'b1;
        end else begin
          state_nxt = FIN;
          res_ld = 1'b1;
        end
      end
      ITER: begin
        md_step = 1'b1;
        if (md_done) begin
          state_nxt = FIN;
          res_ld = 1'b1;
        end
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    res_nxt = state == ITER ? md_res : res_sc;
    flg_nxt = state == ITER ? '0 : flg_sc;
    flg_nxt.zero = res_nxt == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      flg <= '0;
      div_q <= 1'b0;
    end else begin
      if (res_ld) begin
        res <= res_nxt;
        flg <= flg_nxt;
      end
      if (md_load) div_q <= bus.op == OP_DIV;
    end
  end
  ula_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk(clk),
    .rst(rst),
    .load(md_load),
    .mode(div_q),
    .step(md_step),
    .a(a_eff),
    .b(bus.b),
    .done(md_done),
    .result(md_res)
  );
  assign bus.busy = state == ITER || (state == IDLE && bus.start);
  assign bus.done = state == FIN;
  assign bus.result = res;
  assign bus.flag_zero = flg.zero;
  assign bus.flag_carry = flg.carry;
  assign bus.flag_ovf = flg.ovf;
  assign bus.flag_neg = flg.neg;
  assign bus.flag_err = flg.err;
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed vector table plus multi-cycle corner sequences for ula_seq (WIDTH=4)
module tb_ula_seq;
  import ula_pkg::*;
  logic clk, rst;
  int errors = 0;
  int checks = 0;
  ula_seq_if #(.WIDTH(4)) bus();
  ula_seq #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic cin;
    logic [7:0] res;
    logic [4:0] flg;
    int lat;
  } vec_t;
  vec_t v[17];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [4:0] flags();
    return {bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_neg, bus.flag_err};
  endfunction
  task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic sel, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.acc_sel = sel;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 4'h0;
    bus.b = 4'h0;
    bus.acc_sel = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    int lat, extra;
    logic [7:0] acc_exp;
    v[0]  = '{OP_ADD, 4'd9,  4'd8,  1'b1, 8'h12, 5'b01100, 1};
    v[1]  = '{OP_SUB, 4'd3,  4'd5,  1'b0, 8'h0E, 5'b00010, 1};
    v[2]  = '{OP_SUB, 4'd5,  4'd3,  1'b0, 8'h02, 5'b01000, 1};
    v[3]  = '{OP_SUB, 4'd8,  4'd1,  1'b0, 8'h07, 5'b01100, 1};
    v[4]  = '{OP_ADD, 4'd7,  4'd1,  1'b0, 8'h08, 5'b00100, 1};
    v[5]  = '{OP_ADD, 4'd0,  4'd0,  1'b0, 8'h00, 5'b10000, 1};
    v[6]  = '{OP_AND, 4'hC,  4'hA,  1'b0, 8'h08, 5'b00000, 1};
    v[7]  = '{OP_OR,  4'hC,  4'hA,  1'b0, 8'h0E, 5'b00000, 1};
    v[8]  = '{OP_XOR, 4'hC,  4'hA,  1'b0, 8'h06, 5'b00000, 1};
    v[9]  = '{OP_XOR, 4'h5,  4'h5,  1'b0, 8'h00, 5'b10000, 1};
    v[10] = '{OP_MUL, 4'd15, 4'd15, 1'b0, 8'hE1, 5'b00000, 5};
    v[11] = '{OP_MUL, 4'd3,  4'd0,  1'b0, 8'h00, 5'b10000, 5};
    v[12] = '{OP_DIV, 4'd13, 4'd4,  1'b0, 8'h13, 5'b00000, 5};
    v[13] = '{OP_DIV, 4'd7,  4'd0,  1'b0, 8'h7F, 5'b00001, 1};
    v[14] = '{OP_RSV, 4'd5,  4'd3,  1'b0, 8'h00, 5'b10001, 1};
    v[15] = '{OP_DIV, 4'd15, 4'd1,  1'b0, 8'h0F, 5'b00000, 5};
    v[16] = '{OP_ADD, 4'd15, 4'd15, 1'b1, 8'h1F, 5'b01000, 1};
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.a = 4'h0;
    bus.b = 4'h0;
    bus.cin = 1'b0;
    bus.acc_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", {24'd0, bus.result}, 32'd0);
    chk("rst_flags", {27'd0, flags()}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].cin, 1'b0, lat);
      chk($sformatf("vec%0d_result", i), {24'd0, bus.result}, {24'd0, v[i].res});
      chk($sformatf("vec%0d_flags", i), {27'd0, flags()}, {27'd0, v[i].flg});
      chk($sformatf("vec%0d_latency", i), lat, v[i].lat);
      chk($sformatf("vec%0d_busy_at_done", i), {31'd0, bus.busy}, 32'd0);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.a = 4'd15;
    bus.b = 4'd15;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mul_busy_iter", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_ADD;
    bus.a = 4'd1;
    bus.b = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 3;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("mul_ignore_latency", lat, 5);
    chk("mul_ignore_result", {24'd0, bus.result}, 32'hE1);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    chk("mul_ignore_not_queued", extra, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.a = 4'd15;
    bus.b = 4'd15;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_result", {24'd0, bus.result}, 32'd0);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    chk("abort_no_done", extra, 0);
    do_op(OP_ADD, 4'd2, 4'd3, 1'b0, 1'b0, lat);
    chk("post_abort_result", {24'd0, bus.result}, 32'h05);
    chk("post_abort_latency", lat, 1);
    do_op(OP_ADD, 4'd2, 4'd3, 1'b0, 1'b0, lat);
    chk("acc_first", {24'd0, bus.result}, 32'h05);
`ifdef ULA_ACC_EN
    acc_exp = 8'h09;
`else
    acc_exp = 8'h0A;
`endif
    do_op(OP_ADD, 4'd6, 4'd4, 1'b0, 1'b1, lat);
    chk("acc_second", {24'd0, bus.result}, {24'd0, acc_exp});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
